// File: rtl/sm_reg_display.sv
// ---------------------------------------------------------------------------
// sm_reg_display
//   Register-to-LED debug display for board tops. Presents regAddr to the
//   register file and shows one LED_W-bit window of regData on the LEDs.
//   There are two debounced push-buttons. MODE cycles ADDR -> WIN -> AUTO.
//   STEP advances the register address in ADDR mode, or the window in WIN
//   mode. AUTO mode advances the window every SCAN_CYCLES cycles.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous reset, active low
//   key_mode_n  raw mode button, active low, asynchronous to clk
//   key_step_n  raw step button, active low, asynchronous to clk
//   regData     register value for regAddr (combinational read)
//   regAddr     register address presented to the register file
//   led         displayed window, registered
//   mode        current mode: 0 ADDR, 1 WIN, 2 AUTO
// ---------------------------------------------------------------------------
module sm_reg_display #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int LED_W       = 4,
    parameter int DB_CYCLES   = 50000,
    parameter int SCAN_CYCLES = 25000000,
    parameter int RST_ADDR    = 2,
    parameter int RST_WIN     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_mode_n,
    input  logic              key_step_n,
    input  logic [DATA_W-1:0] regData,
    output logic [ADDR_W-1:0] regAddr,
    output logic [LED_W-1:0]  led,
    output logic [1:0]        mode
);

    localparam int NWIN   = DATA_W / LED_W;
    localparam int WIN_W  = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam int SCAN_W = $clog2(SCAN_CYCLES);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(NWIN - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_ADDR = 2'd0,
        MODE_WIN  = 2'd1,
        MODE_AUTO = 2'd2,
        MODE_BAD  = 2'd3
    } mode_t;

    // Index 0 is the mode key and index 1 is the step key.
    logic [1:0] key_raw;
    logic [1:0] press_pulse;

    assign key_raw = {key_step_n, key_mode_n};

    genvar gi;

    // Per-key path: a 2-flop synchroniser followed by a debouncer.
    // The debounced level flips after DB_CYCLES consecutive cycles of
    // disagreement. A cycle of agreement restarts the count.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            pulse_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync2_reg <= sync1_reg;
                    pulse_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg;
                        // Pulse only when the level goes from released to pressed.
                        pulse_reg <= level_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press_pulse[gi] = pulse_reg;
        end
    endgenerate

    logic mode_press;
    logic step_press;

    assign mode_press = press_pulse[0];
    assign step_press = press_pulse[1];

    // Split regData into its display windows.
    logic [LED_W-1:0] win_data [NWIN];

    generate
        for (gi = 0; gi < NWIN; gi++) begin : g_win
            assign win_data[gi] = regData[gi*LED_W +: LED_W];
        end
    endgenerate

    mode_t             mode_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [WIN_W-1:0]  win_reg;
    logic [WIN_W-1:0]  win_inc;
    logic [SCAN_W-1:0] scan_reg;
    logic [LED_W-1:0]  led_reg;

    assign win_inc = (win_reg == WIN_LAST) ? '0 : win_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= MODE_ADDR;
            addr_reg <= ADDR_W'(RST_ADDR);
            win_reg  <= WIN_W'(RST_WIN);
            scan_reg <= '0;
            led_reg  <= '0;
        end else begin
            led_reg <= win_data[win_reg];
            if (mode_press) begin
                // A mode press takes priority over a step press in the same
                // cycle. Every mode change restarts the scan counter.
                scan_reg <= '0;
                case (mode_reg)
                    MODE_ADDR: mode_reg <= MODE_WIN;
                    MODE_WIN:  mode_reg <= MODE_AUTO;
                    default:   mode_reg <= MODE_ADDR;
                endcase
            end else if (mode_reg == MODE_BAD) begin
                mode_reg <= MODE_ADDR;
                scan_reg <= '0;
            end else if (mode_reg == MODE_AUTO) begin
                // Step presses are ignored in AUTO mode.
                if (scan_reg == SCAN_LAST) begin
                    scan_reg <= '0;
                    win_reg  <= win_inc;
                end else begin
                    scan_reg <= scan_reg + 1'b1;
                end
            end else begin
                scan_reg <= '0;
                if (step_press) begin
                    if (mode_reg == MODE_ADDR) begin
                        addr_reg <= addr_reg + 1'b1;
                    end else begin
                        win_reg <= win_inc;
                    end
                end
            end
        end
    end

    assign regAddr = addr_reg;
    assign led     = led_reg;
    assign mode    = mode_reg;

endmodule

// File: tb/tb_sm_reg_display.sv
// ---------------------------------------------------------------------------
// tb_sm_reg_display
//   Directed and random button sequences for sm_reg_display, using
//   DB_CYCLES=4 and SCAN_CYCLES=8. The reference model works at the event
//   level. A press held for at least DB cycles takes effect DB+2 edges after
//   its first sampled edge. AUTO mode advances the window every 8 edges after
//   it is entered. The model predicts the outputs on every cycle.
// ---------------------------------------------------------------------------
module tb_sm_reg_display;

    localparam int DB   = 4;
    localparam int SCAN = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_mode_n;
    logic        key_step_n;
    logic [31:0] reg_data;
    logic [4:0]  reg_addr;
    logic [3:0]  led;
    logic [1:0]  mode;

    logic [31:0] rf [32];

    assign reg_data = rf[reg_addr];

    always #5 clk = ~clk;

    sm_reg_display #(
        .ADDR_W     (5),
        .DATA_W     (32),
        .LED_W      (4),
        .DB_CYCLES  (DB),
        .SCAN_CYCLES(SCAN),
        .RST_ADDR   (2),
        .RST_WIN    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode_n(key_mode_n),
        .key_step_n(key_step_n),
        .regData   (reg_data),
        .regAddr   (reg_addr),
        .led       (led),
        .mode      (mode)
    );

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model state
    int m_addr;
    int m_win;
    int m_mode;
    int m_auto_entry;
    int ev_edge [$];
    int ev_kind [$];   // 0 = mode press, 1 = step press

    task automatic check(input string tag, input int ea, input int em, input int el);
        checks++;
        assert (reg_addr === 5'(ea)) else begin
            errors++;
            $error("FAIL %s regAddr edge %0d: got %0d expected %0d", tag, edge_no, reg_addr, ea);
        end
        checks++;
        assert (mode === 2'(em)) else begin
            errors++;
            $error("FAIL %s mode edge %0d: got %0d expected %0d", tag, edge_no, mode, em);
        end
        checks++;
        assert (led === 4'(el)) else begin
            errors++;
            $error("FAIL %s led edge %0d: got %h expected %h", tag, edge_no, led, el);
        end
    endtask

    task automatic model_reset();
        m_addr       = 2;
        m_win        = 1;
        m_mode       = 0;
        m_auto_entry = 0;
        ev_edge.delete();
        ev_kind.delete();
    endtask

    // Advance one clock edge, update the model for that edge, then compare.
    task automatic clk_step(input string tag);
        int          exp_led;
        logic [31:0] word;
        bit          mode_ev;
        bit          step_ev;
        @(posedge clk);
        edge_no++;
        #1;
        if (!rst_n) begin
            model_reset();
            exp_led = 0;
        end else begin
            // The led shows the window selected before this edge.
            word    = rf[m_addr];
            exp_led = int'(word[m_win*4 +: 4]);
            mode_ev = 1'b0;
            step_ev = 1'b0;
            for (int i = ev_edge.size() - 1; i >= 0; i--) begin
                if (ev_edge[i] == edge_no) begin
                    if (ev_kind[i] == 0) mode_ev = 1'b1;
                    else                 step_ev = 1'b1;
                    ev_edge.delete(i);
                    ev_kind.delete(i);
                end
            end
            if (mode_ev) begin
                m_mode       = (m_mode + 1) % 3;
                m_auto_entry = edge_no;
            end else if (m_mode == 2) begin
                if ((edge_no - m_auto_entry) % SCAN == 0) m_win = (m_win + 1) % 8;
            end else if (step_ev) begin
                if (m_mode == 0) m_addr = (m_addr + 1) % 32;
                else             m_win  = (m_win + 1) % 8;
            end
        end
        check(tag, m_addr, m_mode, exp_led);
    endtask

    // which: 0 = mode, 1 = step, 2 = both. The key is low for `hold` cycles.
    task automatic press(input int which, input int hold, input int gap, input string tag);
        if (hold >= DB) begin
            if (which != 1) begin ev_edge.push_back(edge_no + 3 + DB); ev_kind.push_back(0); end
            if (which != 0) begin ev_edge.push_back(edge_no + 3 + DB); ev_kind.push_back(1); end
        end
        if (which != 1) key_mode_n = 1'b0;
        if (which != 0) key_step_n = 1'b0;
        repeat (hold) clk_step(tag);
        key_mode_n = 1'b1;
        key_step_n = 1'b1;
        repeat (gap) clk_step(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n      = 1'b0;
        key_mode_n = 1'b1;
        key_step_n = 1'b1;
        #1;
        check(tag, 2, 0, 0);
        repeat (2) clk_step(tag);
        rst_n = 1'b1;
        repeat (20) clk_step(tag);
        $display("step %s: reset applied and released", tag);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[2]      = 32'h1234_5678;
        rst_n      = 1'b0;
        key_mode_n = 1'b1;
        key_step_n = 1'b1;
        model_reset();

        // 1. reset values, then led shows window 1 of 0x12345678
        repeat (3) clk_step("reset");
        rst_n = 1'b1;
        repeat (4) clk_step("post_reset");
        $display("step reset: regAddr=%0d mode=%0d led=%h", reg_addr, mode, led);

        // 2. glitch shorter than the debounce time, a long hold, then an address wrap
        press(1, DB - 1, 10, "glitch");
        press(1, 10, 10, "step_hold");
        $display("step step_hold: regAddr=%0d", reg_addr);
        repeat (31) press(1, DB, DB + 4, "addr_wrap");
        $display("step addr_wrap: regAddr=%0d", reg_addr);

        // 3. WIN mode walks the windows
        press(0, 6, 9, "to_win");
        repeat (8) press(1, 6, 9, "win_walk");
        $display("step win_walk: led=%h mode=%0d", led, mode);

        // 4. AUTO mode scan; step presses ignored; back to ADDR holds win
        press(0, 6, 9, "to_auto");
        repeat (40) clk_step("auto_scan");
        press(1, 6, 9, "auto_step");
        press(1, 8, 9, "auto_step");
        press(0, 6, 20, "to_addr");
        $display("step auto: mode=%0d led=%h", mode, led);

        // 5. simultaneous presses: mode wins
        press(2, 6, 10, "both");
        press(2, 6, 10, "both");
        press(2, 6, 10, "both");
        $display("step both: mode=%0d regAddr=%0d", mode, reg_addr);

        // 6. asynchronous reset mid-debounce and mid-scan
        key_step_n = 1'b0;
        repeat (3) clk_step("mid_db");
        async_reset("rst_mid_db");
        press(0, 6, 9, "to_win2");
        press(0, 6, 9, "to_auto2");
        repeat (13) clk_step("mid_scan");
        async_reset("rst_mid_scan");

        // random press sequence
        for (int n = 0; n < 40; n++) begin
            press(int'($urandom_range(0, 2)), int'($urandom_range(1, 10)),
                  int'($urandom_range(DB + 3, DB + 8)), "random");
            $display("step random %0d: regAddr=%0d mode=%0d led=%h", n, reg_addr, mode, led);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
